// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: CPU bus widths,
// the MEM/WB result bundle and the timeout counter sizing helper.
package mem_access_unit_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Results handed to the write-back mux.
  typedef struct packed {
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] alu_c;
    logic [DATA_W-1:0] mem_data;
    logic [REG_W-1:0]  rd;
    logic              regw;
    logic              mem2r;
  } wb_t;

  // Counter must hold 0..TIMEOUT-1; keep at least one bit when TIMEOUT is 0.
  function automatic int cnt_width(input int timeout);
    if (timeout < 1) return 1;
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM load/store controls into a req/ack
// data-memory transaction, stalls the front of the pipe while it is
// outstanding, and registers the MEM/WB results.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] NPC_IN,
  input  logic [DATA_W-1:0] ALU_C_IN,
  input  logic [DATA_W-1:0] RT_DATA_IN,
  input  logic [REG_W-1:0]  reg_rd_in,
  input  logic              MEMR_IN,
  input  logic              MEMW_IN,
  input  logic              REGW_IN,
  input  logic              MEM2R_IN,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic              bus_err,
  output logic [DATA_W-1:0] NPC_OUT,
  output logic [DATA_W-1:0] ALU_C_OUT,
  output logic [DATA_W-1:0] MEM_DATA_OUT,
  output logic [REG_W-1:0]  reg_rd_out,
  output logic              REGW_OUT,
  output logic              MEM2R_OUT
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_d, we_d, err_d;
  logic [DATA_W-1:0]   addr_d, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  wb_t                 wb_q, wb_d, wb_in;
  logic                acc;

  assign acc   = MEMR_IN | MEMW_IN;
  assign wb_in = '{npc: NPC_IN, alu_c: ALU_C_IN, mem_data: '0,
                   rd: reg_rd_in, regw: REGW_IN, mem2r: MEM2R_IN};

  // Stall is gated by reset so an asserted rst releases the pipe immediately.
  assign mem_stall = ~rst & (((state_q == IDLE) & acc) | (state_q == BUSY));

  assign NPC_OUT      = wb_q.npc;
  assign ALU_C_OUT    = wb_q.alu_c;
  assign MEM_DATA_OUT = wb_q.mem_data;
  assign reg_rd_out   = wb_q.rd;
  assign REGW_OUT     = wb_q.regw;
  assign MEM2R_OUT    = wb_q.mem2r;

  // Next-state and next-register values for the access sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = dm_req;
    we_d    = dm_we;
    addr_d  = dm_addr;
    wdata_d = dm_wdata;
    rdata_d = rdata_q;
    err_d   = bus_err;
    wb_d    = wb_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          // Both MEMR and MEMW set is treated as a load.
          req_d      = 1'b1;
          we_d       = MEMW_IN & ~MEMR_IN;
          addr_d     = ALU_C_IN;
          wdata_d    = RT_DATA_IN;
          wb_d.regw  = 1'b0;
          wb_d.mem2r = 1'b0;
          state_d    = BUSY;
        end else begin
          wb_d = wb_in;
        end
      end
      BUSY: begin
        // Bubble while stalled so WB never repeats a register write.
        wb_d.regw  = 1'b0;
        wb_d.mem2r = 1'b0;
        if (dm_ack) begin
          rdata_d = dm_we ? '0 : dm_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // EX/MEM inputs are still the frozen access instruction here.
        wb_d          = wb_in;
        wb_d.mem_data = rdata_q;
        cnt_d         = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs, captured read data, sticky error and MEM/WB results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      rdata_q  <= '0;
      bus_err  <= 1'b0;
      wb_q     <= '0;
    end else begin
      dm_req   <= req_d;
      dm_we    <= we_d;
      dm_addr  <= addr_d;
      dm_wdata <= wdata_d;
      rdata_q  <= rdata_d;
      bus_err  <= err_d;
      wb_q     <= wb_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed instructions, a transaction-level
// expectation model updated by the driver, and a per-cycle compare process.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] NPC_IN = '0, ALU_C_IN = '0, RT_DATA_IN = '0;
  logic [4:0]  reg_rd_in = '0;
  logic        MEMR_IN = 1'b0, MEMW_IN = 1'b0, REGW_IN = 1'b0, MEM2R_IN = 1'b0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        mem_stall, bus_err;
  logic [31:0] NPC_OUT, ALU_C_OUT, MEM_DATA_OUT;
  logic [4:0]  reg_rd_out;
  logic        REGW_OUT, MEM2R_OUT;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .NPC_IN(NPC_IN), .ALU_C_IN(ALU_C_IN), .RT_DATA_IN(RT_DATA_IN),
    .reg_rd_in(reg_rd_in), .MEMR_IN(MEMR_IN), .MEMW_IN(MEMW_IN),
    .REGW_IN(REGW_IN), .MEM2R_IN(MEM2R_IN),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .bus_err(bus_err),
    .NPC_OUT(NPC_OUT), .ALU_C_OUT(ALU_C_OUT), .MEM_DATA_OUT(MEM_DATA_OUT),
    .reg_rd_out(reg_rd_out), .REGW_OUT(REGW_OUT), .MEM2R_OUT(MEM2R_OUT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0, req_cnt = 0, regw_hi = 0, cyc = 0;
  int s0, r0, h0, c0;
  logic chk_en = 1'b0;

  // Expected observable state.
  logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_err = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [31:0] exp_npc = '0, exp_alu = '0, exp_mem = '0;
  logic [4:0]  exp_rd = '0;
  logic        exp_regw = 0, exp_m2r = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus activity counters.
  always @(negedge clk) begin
    cyc++;
    if (mem_stall === 1'b1) stall_cnt++;
    if (dm_req === 1'b1) req_cnt++;
    if (REGW_OUT === 1'b1) regw_hi++;
    if (chk_en) begin
      chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
      chk("dm_req", 32'(dm_req), 32'(exp_req));
      chk("bus_err", 32'(bus_err), 32'(exp_err));
      chk("NPC_OUT", NPC_OUT, exp_npc);
      chk("ALU_C_OUT", ALU_C_OUT, exp_alu);
      chk("MEM_DATA_OUT", MEM_DATA_OUT, exp_mem);
      chk("reg_rd_out", 32'(reg_rd_out), 32'(exp_rd));
      chk("REGW_OUT", 32'(REGW_OUT), 32'(exp_regw));
      chk("MEM2R_OUT", 32'(MEM2R_OUT), 32'(exp_m2r));
      if (exp_req) begin
        chk("dm_we", 32'(dm_we), 32'(exp_we));
        chk("dm_addr", dm_addr, exp_addr);
        chk("dm_wdata", dm_wdata, exp_wdata);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_exp;
    exp_stall = 0; exp_req = 0; exp_err = 0;
    exp_npc = '0; exp_alu = '0; exp_mem = '0; exp_rd = '0;
    exp_regw = 0; exp_m2r = 0;
  endtask

  // Present one EX/MEM instruction, answer the bus ack_at BUSY cycles in
  // (0 or beyond TO = never), and advance the model through it.
  task automatic run_op(input logic [31:0] npc, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [4:0] rd,
                        input logic r, input logic w, input logic rg,
                        input logic m2, input int ack_at, input logic [31:0] rdata);
    logic tmo;
    int   k;
    NPC_IN = npc; ALU_C_IN = alu; RT_DATA_IN = rt; reg_rd_in = rd;
    MEMR_IN = r; MEMW_IN = w; REGW_IN = rg; MEM2R_IN = m2;
    if (!(r | w)) begin
      // Ack outside BUSY must be ignored.
      dm_ack = 1'b1; dm_rdata = 32'hFFFF_0000;
      exp_stall = 0; exp_req = 0;
      step;
      dm_ack = 1'b0;
      exp_npc = npc; exp_alu = alu; exp_mem = '0; exp_rd = rd;
      exp_regw = rg; exp_m2r = m2;
    end else begin
      tmo = !(ack_at >= 1 && ack_at <= TO);
      k   = tmo ? TO : ack_at;
      dm_ack = 1'b0;
      exp_stall = 1; exp_req = 0;
      step;
      exp_regw = 0; exp_m2r = 0;
      exp_req = 1; exp_we = w & ~r; exp_addr = alu; exp_wdata = rt;
      for (int j = 1; j <= k; j++) begin
        dm_ack   = (j == ack_at);
        dm_rdata = (j == ack_at) ? rdata : (32'hBAD0_0000 + 32'(j));
        step;
      end
      dm_ack = 1'b1; dm_rdata = 32'h5555_AAAA;
      exp_req = 0; exp_stall = 0;
      if (tmo) exp_err = 1;
      step;
      dm_ack = 1'b0;
      exp_npc = npc; exp_alu = alu; exp_rd = rd; exp_regw = rg; exp_m2r = m2;
      exp_mem = (r && !tmo) ? rdata : 32'h0;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst dm_req", 32'(dm_req), 32'h0);
    chk("rst mem_stall", 32'(mem_stall), 32'h0);
    chk("rst bus_err", 32'(bus_err), 32'h0);
    chk("rst NPC_OUT", NPC_OUT, 32'h0);
    chk("rst REGW_OUT", 32'(REGW_OUT), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    zero_exp();
    chk_en = 1'b1;

    // ALU op passes through with one cycle latency.
    s0 = stall_cnt; r0 = req_cnt;
    run_op(32'h4, 32'h10, 32'h0, 5'd5, 0, 0, 1, 0, 0, 32'h0);
    chk("t1 ALU_C_OUT", ALU_C_OUT, 32'h10);
    chk("t1 REGW_OUT", 32'(REGW_OUT), 32'h1);
    chk("t1 reg_rd_out", 32'(reg_rd_out), 32'd5);
    chk("t1 stalls", 32'(stall_cnt - s0), 32'd0);
    chk("t1 reqs", 32'(req_cnt - r0), 32'd0);

    // Load, ack on third BUSY cycle.
    s0 = stall_cnt; r0 = req_cnt;
    run_op(32'h8, 32'h100, 32'h0, 5'd7, 1, 0, 1, 1, 3, 32'hDEADBEEF);
    chk("t2 stalls", 32'(stall_cnt - s0), 32'd4);
    chk("t2 reqs", 32'(req_cnt - r0), 32'd3);
    chk("t2 MEM_DATA_OUT", MEM_DATA_OUT, 32'hDEADBEEF);
    chk("t2 MEM2R_OUT", 32'(MEM2R_OUT), 32'h1);
    chk("t2 dm_addr", dm_addr, 32'h100);
    chk("t2 dm_we", 32'(dm_we), 32'h0);

    // Store, ack on first BUSY cycle; read bus carries junk that must not land.
    s0 = stall_cnt; r0 = req_cnt;
    run_op(32'hC, 32'h20, 32'h1234, 5'd0, 0, 1, 0, 0, 1, 32'h7777_7777);
    chk("t3 reqs", 32'(req_cnt - r0), 32'd1);
    chk("t3 stalls", 32'(stall_cnt - s0), 32'd2);
    chk("t3 dm_we", 32'(dm_we), 32'h1);
    chk("t3 dm_wdata", dm_wdata, 32'h1234);
    chk("t3 MEM_DATA_OUT", MEM_DATA_OUT, 32'h0);
    chk("t3 REGW_OUT", 32'(REGW_OUT), 32'h0);

    // MEMR and MEMW both set behaves as a load.
    run_op(32'h10, 32'h40, 32'h9999, 5'd9, 1, 1, 1, 1, 2, 32'hCAFEF00D);
    chk("both MEM_DATA_OUT", MEM_DATA_OUT, 32'hCAFEF00D);

    // Ack on the final timeout cycle wins.
    r0 = req_cnt;
    run_op(32'h14, 32'h300, 32'h0, 5'd2, 1, 0, 1, 1, 4, 32'h0BAD_F00D);
    chk("t4a reqs", 32'(req_cnt - r0), 32'd4);
    chk("t4a bus_err", 32'(bus_err), 32'h0);
    chk("t4a MEM_DATA_OUT", MEM_DATA_OUT, 32'h0BAD_F00D);

    // No ack: abort after TO cycles, sticky error, zero load data.
    r0 = req_cnt;
    run_op(32'h18, 32'h304, 32'h0, 5'd3, 1, 0, 1, 1, 0, 32'h0);
    chk("t4b reqs", 32'(req_cnt - r0), 32'd4);
    chk("t4b bus_err", 32'(bus_err), 32'h1);
    chk("t4b MEM_DATA_OUT", MEM_DATA_OUT, 32'h0);
    run_op(32'h1C, 32'h55, 32'h0, 5'd1, 0, 0, 1, 0, 0, 32'h0);
    chk("t4b sticky", 32'(bus_err), 32'h1);

    // Back-to-back loads with immediate ack.
    run_op(32'h20, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    s0 = stall_cnt; h0 = regw_hi; c0 = cyc;
    run_op(32'h24, 32'h200, 32'h0, 5'd3, 1, 0, 1, 1, 1, 32'h1111_1111);
    chk("t6 cycles A", 32'(cyc - c0), 32'd3);
    chk("t6 data A", MEM_DATA_OUT, 32'h1111_1111);
    c0 = cyc;
    run_op(32'h28, 32'h204, 32'h0, 5'd4, 1, 0, 1, 1, 1, 32'h2222_2222);
    chk("t6 cycles B", 32'(cyc - c0), 32'd3);
    chk("t6 data B", MEM_DATA_OUT, 32'h2222_2222);
    run_op(32'h2C, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
    chk("t6 stalls", 32'(stall_cnt - s0), 32'd4);
    chk("t6 regw pulses", 32'(regw_hi - h0), 32'd2);

    // Reset in the middle of BUSY.
    run_op(32'h30, 32'h60, 32'h0, 5'd6, 0, 0, 1, 1, 0, 32'h0);
    chk_en = 1'b0;
    NPC_IN = 32'h34; ALU_C_IN = 32'h400; reg_rd_in = 5'd8;
    MEMR_IN = 1; MEMW_IN = 0; REGW_IN = 1; MEM2R_IN = 1;
    dm_ack = 1'b0;
    step;
    step;
    chk("t5 pre req", 32'(dm_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5 dm_req", 32'(dm_req), 32'h0);
    chk("t5 mem_stall", 32'(mem_stall), 32'h0);
    chk("t5 NPC_OUT", NPC_OUT, 32'h0);
    chk("t5 ALU_C_OUT", ALU_C_OUT, 32'h0);
    chk("t5 MEM_DATA_OUT", MEM_DATA_OUT, 32'h0);
    chk("t5 reg_rd_out", 32'(reg_rd_out), 32'h0);
    chk("t5 REGW_OUT", 32'(REGW_OUT), 32'h0);
    chk("t5 MEM2R_OUT", 32'(MEM2R_OUT), 32'h0);
    chk("t5 bus_err", 32'(bus_err), 32'h0);
    chk("t5 dm_addr", dm_addr, 32'h0);
    MEMR_IN = 0; REGW_IN = 0; MEM2R_IN = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    zero_exp();
    chk_en = 1'b1;
    s0 = stall_cnt;
    run_op(32'h38, 32'h77, 32'h0, 5'd11, 0, 0, 1, 0, 0, 32'h0);
    chk("t5 idle after rst", 32'(stall_cnt - s0), 32'd0);
    chk("t5 ALU_C_OUT after", ALU_C_OUT, 32'h77);
    run_op(32'h3C, 32'h500, 32'h0, 5'd12, 1, 0, 1, 1, 2, 32'hA5A5_5A5A);
    chk("t5 load after", MEM_DATA_OUT, 32'hA5A5_5A5A);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
